dmem_bus_if: RTL and testbench

- M-stage data-memory bus master, directly downstream of the M-stage memory access controller (byte-enable/write-data/load-extend logic).
- Takes that block's lane-0-justified store data and byte enables, lane-shifts them by addr[1:0], and runs an SRAM-like req/addr_ok/data_ok transaction.
- Returns the read word right-justified to lane 0 for load extension.
- Stalls the pipeline while a transaction is outstanding.

---
 rtl/dmem_bus_if_pkg.sv | 24 ++
 rtl/dmem_bus_if_if.sv | 22 ++
 rtl/dmem_lane_align.sv | 24 ++
 rtl/dmem_bus_if.sv | 150 +++++++++++++++
 tb/tb_dmem_bus_if.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_bus_if_pkg.sv
// Shared types for the M-stage data-memory bus master: FSM states, bus size
// codes and the byte-enable to transfer-size mapping.
package dmem_bus_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  function automatic logic [1:0] size_of(input logic [3:0] dm_byte);
    case (dm_byte)
      4'b0001: size_of = SIZE_B;
      4'b0011: size_of = SIZE_H;
      default: size_of = SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bus_if_if.sv
// SRAM-like req/addr_ok/data_ok data bus between the M-stage master and memory.
interface dmem_bus_if_if #(parameter int ADDR_W = 32);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment: shifts lane-0 store data/strobes up by the address
// offset and shifts the raw read word back down to lane 0.
module dmem_lane_align
  import dmem_bus_if_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  off,
  input  logic [3:0]  dm_byte,
  input  logic [31:0] wdata,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_sh,
  output logic [1:0]  size,
  output logic [31:0] rdata_sh
);

  // Loads always fetch the full aligned word; lane selection happens on return.
  assign wstrb    = we ? (dm_byte << off) : 4'b0000;
  assign wdata_sh = wdata << {off, 3'b000};
  assign size     = we ? size_of(dm_byte) : SIZE_W;
  assign rdata_sh = rdata >> {rd_off, 3'b000};

endmodule

// File: rtl/dmem_bus_if.sv
// M-stage data-memory bus master: issues one req/addr_ok/data_ok transaction
// per load/store, stalls the pipeline while it is outstanding.
module dmem_bus_if
  import dmem_bus_if_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en_M,
  input  logic              mem_we_M,
  input  logic [ADDR_W-1:0] addr_M,
  input  logic [3:0]        dm_byte_M,
  input  logic [31:0]       wdata_M,
  input  logic              exc_M,
  input  logic              flush,
  input  logic              advance_M,
  output logic [31:0]       rdata_M,
  output logic              stall_M,
  dmem_bus_if_if.master     bus
);

  state_t state, state_nxt;
  logic   cancel, cancel_nxt;
  logic   start, issue, capture;

  logic [ADDR_W-1:0] cur_addr;
  logic [3:0]        cur_wstrb;
  logic [31:0]       cur_wdata;
  logic [1:0]        cur_size;
  logic [31:0]       rdata_sh;
  logic [1:0]        rd_off;

  logic              held_we;
  logic [ADDR_W-1:0] held_addr;
  logic [3:0]        held_wstrb;
  logic [31:0]       held_wdata;
  logic [1:0]        held_size;
  logic [1:0]        held_off;

  assign start = mem_en_M & ~exc_M & ~flush & (~mem_we_M | (dm_byte_M != 4'b0000));
  // Masked by rst so the bus stays quiet while reset is held, not just after it.
  assign issue = (state == IDLE) & start & ~rst;

  assign cur_addr = mem_we_M ? addr_M : {addr_M[ADDR_W-1:2], 2'b00};
  assign rd_off   = issue ? addr_M[1:0] : held_off;

  dmem_lane_align u_align (
    .we      (mem_we_M),
    .off     (addr_M[1:0]),
    .dm_byte (dm_byte_M),
    .wdata   (wdata_M),
    .rd_off  (rd_off),
    .rdata   (bus.data_rdata),
    .wstrb   (cur_wstrb),
    .wdata_sh(cur_wdata),
    .size    (cur_size),
    .rdata_sh(rdata_sh)
  );

  // Issue-cycle snapshot: keeps REQ fields stable even if M is flushed.
  always_ff @(posedge clk) begin
    if (issue) begin
      held_we    <= mem_we_M;
      held_addr  <= cur_addr;
      held_wstrb <= cur_wstrb;
      held_wdata <= cur_wdata;
      held_size  <= cur_size;
      held_off   <= addr_M[1:0];
    end
  end

  always_comb begin
    state_nxt      = state;
    cancel_nxt     = cancel;
    capture        = 1'b0;
    stall_M        = 1'b0;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_size  = 2'b00;
    bus.data_addr  = '0;
    bus.data_wstrb = 4'b0000;
    bus.data_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (issue) begin
          stall_M        = 1'b1;
          bus.data_req   = 1'b1;
          bus.data_wr    = mem_we_M;
          bus.data_size  = cur_size;
          bus.data_addr  = cur_addr;
          bus.data_wstrb = cur_wstrb;
          bus.data_wdata = cur_wdata;
          if (bus.data_addr_ok && bus.data_data_ok) begin
            state_nxt = DONE;
            capture   = ~mem_we_M;
          end else if (bus.data_addr_ok) begin
            state_nxt = WAIT;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        stall_M        = 1'b1;
        bus.data_req   = 1'b1;
        bus.data_wr    = held_we;
        bus.data_size  = held_size;
        bus.data_addr  = held_addr;
        bus.data_wstrb = held_wstrb;
        bus.data_wdata = held_wdata;
        if (bus.data_addr_ok && bus.data_data_ok) begin
          state_nxt  = (cancel | flush) ? IDLE : DONE;
          capture    = ~held_we & ~(cancel | flush);
          cancel_nxt = 1'b0;
        end else begin
          cancel_nxt = cancel | flush;
          if (bus.data_addr_ok) state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall_M = 1'b1;
        if (bus.data_data_ok) begin
          state_nxt  = (cancel | flush) ? IDLE : DONE;
          capture    = ~held_we & ~(cancel | flush);
          cancel_nxt = 1'b0;
        end else begin
          cancel_nxt = cancel | flush;
        end
      end
      DONE: begin
        if (advance_M || flush) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cancel  <= 1'b0;
      rdata_M <= 32'h0;
    end else begin
      state  <= state_nxt;
      cancel <= cancel_nxt;
      if (capture) rdata_M <= rdata_sh;
    end
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Self-checking bench for dmem_bus_if: directed scenarios plus randomized
// transactions against a transaction-level reference model.
module tb_dmem_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en_M, mem_we_M, exc_M, flush, advance_M;
  logic [31:0] addr_M, wdata_M, rdata_M;
  logic [3:0]  dm_byte_M;
  logic        stall_M;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_rdata = 32'h0;

  dmem_bus_if_if #(.ADDR_W(32)) bus ();

  dmem_bus_if #(.ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_en_M (mem_en_M),
    .mem_we_M (mem_we_M),
    .addr_M   (addr_M),
    .dm_byte_M(dm_byte_M),
    .wdata_M  (wdata_M),
    .exc_M    (exc_M),
    .flush    (flush),
    .advance_M(advance_M),
    .rdata_M  (rdata_M),
    .stall_M  (stall_M),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_addr(input bit we, input logic [31:0] a);
    return we ? a : (a / 4) * 4;
  endfunction

  function automatic logic [1:0] m_size(input bit we, input logic [3:0] dm);
    if (!we) return 2'd2;
    if (dm == 4'd1) return 2'd0;
    if (dm == 4'd3) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [3:0] m_wstrb(input bit we, input logic [3:0] dm, input logic [31:0] a);
    int v;
    if (!we) return 4'd0;
    v = (int'(dm) * (2 ** (a % 4))) % 16;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [31:0] a);
    longint unsigned v;
    v = (longint'(wd) * (64'd1 << (8 * (a % 4)))) % (64'd1 << 32);
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] rd, input logic [31:0] a);
    return rd / (32'd1 << (8 * (a % 4)));
  endfunction

  task automatic idle_inputs();
    mem_en_M = 0; mem_we_M = 0; addr_M = 0; dm_byte_M = 0; wdata_M = 0;
    exc_M = 0; flush = 0; advance_M = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 0;
  endtask

  // addr_ok arrives aok cycles after issue, data_ok dok cycles after that;
  // fl >= 1 flushes M at that cycle of the transaction.
  task automatic run_txn(input bit we, input logic [31:0] a, input logic [3:0] dm,
                         input logic [31:0] wd, input logic [31:0] rd, input int aok,
                         input int dok, input int fl, input bit dflush, input string nm);
    int  last;
    bit  canc;
    bit  ereq;
    logic [31:0] ea, ewd;
    logic [1:0]  es;
    logic [3:0]  ew;
    last = aok + dok;
    canc = (fl >= 0);
    ea = m_addr(we, a); es = m_size(we, dm); ew = m_wstrb(we, dm, a); ewd = m_wdata(wd, a);
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (canc && c >= fl) begin
        mem_en_M = 0; flush = (c == fl); addr_M = $urandom; wdata_M = $urandom;
      end else begin
        mem_en_M = 1; mem_we_M = we; addr_M = a; dm_byte_M = dm; wdata_M = wd; flush = 0;
      end
      exc_M = (c > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      advance_M = 0;
      bus.data_addr_ok = (c == aok);
      bus.data_data_ok = (c == last);
      bus.data_rdata = (c == last) ? rd : $urandom;
      #1;
      ereq = (c <= aok);
      n_checks++;
      if (bus.data_req !== ereq) begin
        n_fail++; $display("FAIL %s c%0d data_req: got %b want %b", nm, c, bus.data_req, ereq);
      end
      n_checks++;
      if (stall_M !== 1'b1) begin
        n_fail++; $display("FAIL %s c%0d stall_M: got %b want 1", nm, c, stall_M);
      end
      if (ereq) begin
        n_checks++;
        if (bus.data_addr !== ea || bus.data_size !== es || bus.data_wstrb !== ew ||
            bus.data_wr !== we) begin
          n_fail++;
          $display("FAIL %s c%0d fields: got addr=%h size=%0d wstrb=%b wr=%b want addr=%h size=%0d wstrb=%b wr=%b",
                   nm, c, bus.data_addr, bus.data_size, bus.data_wstrb, bus.data_wr, ea, es, ew, we);
        end
        if (we) begin
          n_checks++;
          if (bus.data_wdata !== ewd) begin
            n_fail++; $display("FAIL %s c%0d wdata: got %h want %h", nm, c, bus.data_wdata, ewd);
          end
        end
      end
    end
    if (!canc && !we) exp_rdata = m_rdata(rd, a);
    @(negedge clk);
    bus.data_addr_ok = 0; bus.data_data_ok = 0; flush = 0; advance_M = 0; exc_M = 0;
    #1;
    n_checks++;
    if (bus.data_req !== 1'b0 || stall_M !== 1'b0 || rdata_M !== exp_rdata) begin
      n_fail++;
      $display("FAIL %s after: got req=%b stall=%b rdata=%h want req=0 stall=0 rdata=%h",
               nm, bus.data_req, stall_M, rdata_M, exp_rdata);
    end
    if (!canc) begin
      @(negedge clk);
      if (dflush) flush = 1; else advance_M = 1;
      #1;
      n_checks++;
      if (bus.data_req !== 1'b0 || stall_M !== 1'b0 || rdata_M !== exp_rdata) begin
        n_fail++;
        $display("FAIL %s done-exit: got req=%b stall=%b rdata=%h want req=0 stall=0 rdata=%h",
                 nm, bus.data_req, stall_M, rdata_M, exp_rdata);
      end
      @(negedge clk);
      flush = 0; advance_M = 0; mem_en_M = 0;
      #1;
      n_checks++;
      if (bus.data_req !== 1'b0 || stall_M !== 1'b0) begin
        n_fail++; $display("FAIL %s idle: got req=%b stall=%b want 0 0", nm, bus.data_req, stall_M);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    mem_en_M = 1; addr_M = 32'h40;
    @(negedge clk); #1;
    n_checks++;
    if (bus.data_req !== 1'b0 || stall_M !== 1'b0 || rdata_M !== 32'h0 || bus.data_wr !== 1'b0 ||
        bus.data_addr !== 32'h0 || bus.data_wstrb !== 4'h0 || bus.data_size !== 2'd0) begin
      n_fail++;
      $display("FAIL reset: got req=%b stall=%b rdata=%h wr=%b addr=%h wstrb=%b size=%0d want all 0",
               bus.data_req, stall_M, rdata_M, bus.data_wr, bus.data_addr, bus.data_wstrb, bus.data_size);
    end
    @(negedge clk);
    rst = 0; mem_en_M = 0;
    #1;
    n_checks++;
    if (bus.data_req !== 1'b0 || stall_M !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got req=%b stall=%b want 0 0", bus.data_req, stall_M);
    end
  endtask

  task automatic test_word_load();
    run_txn(0, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF, 0, 2, -1, 0, "word_load");
  endtask

  task automatic test_byte_store();
    run_txn(1, 32'h103, 4'b0001, 32'h000000A5, 32'h0, 1, 1, -1, 1, "byte_store");
  endtask

  task automatic test_half_load();
    run_txn(0, 32'h202, 4'b0000, 32'h0, 32'h1234ABCD, 0, 0, -1, 0, "half_load");
    n_checks++;
    if (rdata_M !== 32'h00001234) begin
      n_fail++; $display("FAIL half_load value: got %h want 00001234", rdata_M);
    end
  endtask

  task automatic test_addr_ok_withheld();
    run_txn(1, 32'h302, 4'b0011, 32'h0000BEEF, 32'h0, 3, 1, -1, 0, "addr_ok_withheld");
  endtask

  task automatic test_flush_wait();
    run_txn(0, 32'h408, 4'b0000, 32'h0, 32'hCAFEF00D, 0, 3, 1, 0, "flush_wait");
    run_txn(0, 32'h501, 4'b0000, 32'h0, 32'h89ABCDEF, 1, 1, -1, 0, "after_flush");
  endtask

  task automatic test_exc();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      idle_inputs();
      mem_en_M = 1;
      case (c)
        0, 1, 2: begin mem_we_M = 1; dm_byte_M = 4'b1111; addr_M = 32'h600; exc_M = 1; end
        3:       begin mem_we_M = 1; dm_byte_M = 4'b0000; addr_M = 32'h604; end
        default: begin mem_we_M = 0; addr_M = 32'h608; flush = 1; end
      endcase
      #1;
      n_checks++;
      if (bus.data_req !== 1'b0 || stall_M !== 1'b0) begin
        n_fail++; $display("FAIL exc_noreq c%0d: got req=%b stall=%b want 0 0", c, bus.data_req, stall_M);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_req();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle_inputs();
      mem_en_M = 1; addr_M = 32'h700;
      #1;
      n_checks++;
      if (bus.data_req !== 1'b1 || stall_M !== 1'b1) begin
        n_fail++; $display("FAIL rst_mid_req pre c%0d: got req=%b stall=%b want 1 1", c, bus.data_req, stall_M);
      end
    end
    #1 rst = 1;
    exp_rdata = 32'h0;
    #1;
    n_checks++;
    if (bus.data_req !== 1'b0 || stall_M !== 1'b0 || rdata_M !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_req async: got req=%b stall=%b rdata=%h want 0 0 0", bus.data_req, stall_M, rdata_M);
    end
    @(negedge clk);
    rst = 0; mem_en_M = 0;
    #1;
    n_checks++;
    if (bus.data_req !== 1'b0 || stall_M !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_req idle: got req=%b stall=%b want 0 0", bus.data_req, stall_M);
    end
    run_txn(0, 32'h704, 4'b0000, 32'h0, 32'h55AA1234, 0, 1, -1, 0, "after_rst");
  endtask

  task automatic test_random();
    bit          we;
    logic [3:0]  dm;
    int          aok, dok, fl, sel;
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 2);
      dm  = !we ? 4'b0000 : (sel == 0) ? 4'b0001 : (sel == 1) ? 4'b0011 : 4'b1111;
      aok = $urandom_range(0, 3);
      dok = $urandom_range(0, 3);
      fl  = -1;
      if (aok + dok >= 1 && $urandom_range(0, 3) == 0) fl = $urandom_range(1, aok + dok);
      run_txn(we, $urandom, dm, $urandom, $urandom, aok, dok, fl, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_half_load();
    test_addr_ok_withheld();
    test_flush_wait();
    test_exc();
    test_reset_mid_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
